// File: rtl/alu_issue_receiver.sv
// Functional-unit side of the issue handshake: select -> fixed-latency EXEC -> WB valid/ack.
// Optional one-entry skid buffer for overrun selects, enabled by ISSUE_RECV_SKID_EN.
module alu_issue_receiver #(
  parameter int WFID_W       = 6,
  parameter int OPCODE_W     = 32,
  parameter int EXEC_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_select,
  input  logic [WFID_W-1:0]   alu_wfid,
  input  logic [OPCODE_W-1:0] alu_opcode,
  output logic                alu_ready,
  output logic                exec_valid,
  output logic [WFID_W-1:0]   exec_wfid,
  output logic [OPCODE_W-1:0] exec_opcode,
  output logic                done_valid,
  output logic [WFID_W-1:0]   done_wfid,
  input  logic                done_ack,
  output logic                err_overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_LATENCY - 1);

  state_t                state_r, state_s;
  logic [3:0]            cnt_r;
  logic [WFID_W-1:0]     wfid_r;
  logic [OPCODE_W-1:0]   opcode_r;
  logic                  ready_r, exec_valid_r, done_valid_r, err_r;
  logic                  load_sel_s, load_skid_s, reject_s, overrun_s;
  logic                  skid_full_s, skid_next_s, ready_s;
  logic [WFID_W-1:0]     skid_wfid_s;
  logic [OPCODE_W-1:0]   skid_opcode_s;

  // Next-state selection; a pending skid entry always takes priority over a new select
  always_comb begin
    state_s     = state_r;
    load_sel_s  = 1'b0;
    load_skid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (skid_full_s) begin
          state_s     = EXEC;
          load_skid_s = 1'b1;
        end else if (alu_select) begin
          state_s    = EXEC;
          load_sel_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r <= 4'd1) begin
          state_s = WB;
        end else begin
          state_s = EXEC;
        end
      end
      WB: begin
        if (done_ack && skid_full_s) begin
          state_s     = EXEC;
          load_skid_s = 1'b1;
        end else if (done_ack) begin
          state_s = IDLE;
        end else begin
          state_s = WB;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign reject_s = alu_select & ~load_sel_s;
  assign ready_s  = (state_s == IDLE) & ~skid_next_s;

`ifdef ISSUE_RECV_SKID_EN
  logic                skid_full_r;
  logic [WFID_W-1:0]   skid_wfid_r;
  logic [OPCODE_W-1:0] skid_opcode_r;

  assign skid_full_s   = skid_full_r;
  assign skid_wfid_s   = skid_wfid_r;
  assign skid_opcode_s = skid_opcode_r;
  assign overrun_s     = reject_s & skid_full_r;

  // Skid occupancy: first rejected select fills it, a launch from it empties it
  always_comb begin
    skid_next_s = skid_full_r;
    if (reject_s && !skid_full_r) begin
      skid_next_s = 1'b1;
    end else if (load_skid_s) begin
      skid_next_s = 1'b0;
    end else begin
      skid_next_s = skid_full_r;
    end
  end

  // Skid storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_full_r   <= 1'b0;
      skid_wfid_r   <= {WFID_W{1'b0}};
      skid_opcode_r <= {OPCODE_W{1'b0}};
    end else begin
      skid_full_r <= skid_next_s;
      if (reject_s && !skid_full_r) begin
        skid_wfid_r   <= alu_wfid;
        skid_opcode_r <= alu_opcode;
      end
    end
  end
`else
  assign skid_full_s   = 1'b0;
  assign skid_next_s   = 1'b0;
  assign skid_wfid_s   = {WFID_W{1'b0}};
  assign skid_opcode_s = {OPCODE_W{1'b0}};
  assign overrun_s     = reject_s;
`endif

  // State, latency counter, instruction latch and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      wfid_r       <= {WFID_W{1'b0}};
      opcode_r     <= {OPCODE_W{1'b0}};
      ready_r      <= 1'b0;
      exec_valid_r <= 1'b0;
      done_valid_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      ready_r      <= ready_s;
      exec_valid_r <= (state_s == EXEC);
      done_valid_r <= (state_s == WB);
      err_r        <= err_r | overrun_s;
      if (load_sel_s) begin
        cnt_r    <= CNT_LOAD;
        wfid_r   <= alu_wfid;
        opcode_r <= alu_opcode;
      end else if (load_skid_s) begin
        cnt_r    <= CNT_LOAD;
        wfid_r   <= skid_wfid_s;
        opcode_r <= skid_opcode_s;
      end else if (cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  assign alu_ready   = ready_r;
  assign exec_valid  = exec_valid_r;
  assign exec_wfid   = wfid_r;
  assign exec_opcode = opcode_r;
  assign done_valid  = done_valid_r;
  assign done_wfid   = wfid_r;
  assign err_overrun = err_r;

endmodule
